alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer.sv | 81 ++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer feeding the 4-bit adder stage: it latches one operation, lets the adder settle
// for a cycle, then captures sum/cout into the accumulator and pulses res_valid.
module alu_op_sequencer #(
  parameter int unsigned OPS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_operand,
  output logic             c1,
  output logic             c2,
  output logic [3:0]       ia,
  output logic [3:0]       ib,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic [3:0]       acc,
  output logic             carry,
  output logic             zero,
  output logic             res_valid,
  output logic [OPS_W-1:0] ops_done
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc       <= 4'd0;
      carry     <= 1'b0;
      ia        <= 4'd0;
      c1        <= 1'b0;
      c2        <= 1'b0;
      res_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      res_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_load) begin
              acc       <= cmd_operand;
              carry     <= 1'b0;
              res_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              {c1, c2} <= cmd_op;
              ia       <= cmd_operand;
              state_q  <= StDrive;
            end
          end
        end
        StDrive: begin
          // Adder has had a full cycle to settle on the registered operands.
          acc       <= sum;
          carry     <= cout;
          res_valid <= 1'b1;
          if (ops_done != {OPS_W{1'b1}}) begin
            ops_done <= ops_done + 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign ib        = acc;
  assign zero      = (acc == 4'd0);

endmodule
